// File: rtl/softmax_argmax_ctrl.sv
// rtl/softmax_argmax_ctrl.sv - sequential argmax over the FC output buffer
// Streams LAYER_SZ signed values, tracks the running maximum and reports its index.
module softmax_argmax_ctrl #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10,
    parameter int ADDR_W   = ($clog2(LAYER_SZ) > 1) ? $clog2(LAYER_SZ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [SIZE-1:0]   rd_data,
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   class_out,
    output logic [SIZE-1:0]   max_value
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAYER_SZ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_valid;
    logic                    r_first;
    logic [ADDR_W-1:0]       r_vaddr;
    logic [ADDR_W-1:0]       r_idx;
    logic signed [SIZE-1:0]  r_max;
    logic                    w_take;

    // Strict greater-than keeps the lowest index on ties.
    assign w_take = r_valid && (r_first || ($signed(rd_data) > r_max));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_first   <= 1'b0;
            r_vaddr   <= '0;
            r_idx     <= '0;
            r_max     <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= '0;
            max_value <= '0;
        end else begin
            done    <= 1'b0;
            r_valid <= rd_en;
            r_vaddr <= rd_addr;
            if (w_take) begin
                r_max <= $signed(rd_data);
                r_idx <= r_vaddr;
            end
            if (r_valid) begin
                r_first <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        r_first <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_addr == LAST_ADDR) begin
                        r_state <= S_LAST;
                        rd_en   <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                S_LAST: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // The final sample was folded in at the end of LAST.
                    class_out <= SIZE'(r_idx);
                    max_value <= r_max;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_argmax_ctrl.sv
// tb/tb_softmax_argmax_ctrl.sv - scoreboard bench for softmax_argmax_ctrl
// Three instances (LAYER_SZ 2, 10, 1) share clock and reset.
module tb_softmax_argmax_ctrl;

    typedef struct {
        logic [15:0] cls;
        logic [15:0] mx;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s2, s10, s1;
    logic        en2, en10, en1;
    logic [0:0]  addr2, addr1;
    logic [3:0]  addr10;
    logic [15:0] d2, d10, d1;
    logic        busy2, busy10, busy1;
    logic        done2, done10, done1;
    logic [15:0] cls2, cls10, cls1;
    logic [15:0] mx2, mx10, mx1;

    logic [15:0] m2[2];
    logic [15:0] m10[10];
    logic [15:0] m1[1];

    exp_t q2[$];
    exp_t q10[$];
    exp_t q1[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int a10_exp = 0;

    softmax_argmax_ctrl #(.SIZE(16), .LAYER_SZ(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2), .rd_en(en2), .rd_addr(addr2), .rd_data(d2),
        .busy(busy2), .done(done2), .class_out(cls2), .max_value(mx2)
    );
    softmax_argmax_ctrl #(.SIZE(16), .LAYER_SZ(10)) u_dut10 (
        .clk(clk), .rst(rst), .start(s10), .rd_en(en10), .rd_addr(addr10), .rd_data(d10),
        .busy(busy10), .done(done10), .class_out(cls10), .max_value(mx10)
    );
    softmax_argmax_ctrl #(.SIZE(16), .LAYER_SZ(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .rd_en(en1), .rd_addr(addr1), .rd_data(d1),
        .busy(busy1), .done(done1), .class_out(cls1), .max_value(mx1)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d2  <= m2[addr2];
        d10 <= m10[addr10];
        d1  <= m1[addr1];
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            if (q2.size() == 0) chk("unexpected_done2", 32'(done2), 32'(0));
            else begin
                e = q2.pop_front();
                chk("class2", 32'(cls2), 32'(e.cls));
                chk("max2", 32'(mx2), 32'(e.mx));
                chk("done_cycle2", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done10) begin
            if (q10.size() == 0) chk("unexpected_done10", 32'(done10), 32'(0));
            else begin
                e = q10.pop_front();
                chk("class10", 32'(cls10), 32'(e.cls));
                chk("max10", 32'(mx10), 32'(e.mx));
                chk("done_cycle10", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 32'(done1), 32'(0));
            else begin
                e = q1.pop_front();
                chk("class1", 32'(cls1), 32'(e.cls));
                chk("max1", 32'(mx1), 32'(e.mx));
                chk("done_cycle1", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Read-address sequence of the 10-entry instance: 0..9 exactly once per run.
    always @(negedge clk) begin
        if (rst) begin
            a10_exp = 0;
        end else begin
            if (en10) begin
                chk("rd_addr10", 32'(addr10), 32'(a10_exp));
                a10_exp++;
            end
            if (done10) begin
                chk("reads_per_run10", 32'(a10_exp), 32'(10));
                a10_exp = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q1.size() + q2.size() + q10.size()) != 0; i++) tick(1);
        chk("drain_timeout", 32'(q1.size() + q2.size() + q10.size()), 32'(0));
        tick(2);
    endtask

    task automatic push(input int which, input logic [15:0] c, input logic [15:0] m, input int at);
        exp_t e;
        e.cls = c;
        e.mx  = m;
        e.cyc = at;
        if (which == 2) q2.push_back(e);
        else if (which == 10) q10.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pulse10();
        s10 = 1'b1;
        tick(1);
        s10 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s2 = 1'b0; s10 = 1'b0; s1 = 1'b0;
        foreach (m2[i]) m2[i] = '0;
        foreach (m10[i]) m10[i] = '0;
        m1[0] = '0;
        tick(3);
        rst = 1'b0;
        chk("reset_rd_en", 32'(en2), 32'(0));
        chk("reset_busy", 32'(busy2), 32'(0));
        chk("reset_done", 32'(done2), 32'(0));
        chk("reset_rd_addr", 32'(addr10), 32'(0));
        chk("reset_class", 32'(cls10), 32'(0));
        chk("reset_max", 32'(mx1), 32'(0));

        m2[0] = 16'h0800; m2[1] = 16'h0900;
        push(2, 16'd1, 16'h0900, cyc + 5);
        s2 = 1'b1; tick(1); s2 = 1'b0;
        chk("busy_after_start", 32'(busy2), 32'(1));
        drain();

        m2[0] = 16'h7F00; m2[1] = 16'h8000;
        push(2, 16'd0, 16'h7F00, cyc + 5);
        s2 = 1'b1; tick(1); s2 = 1'b0;
        drain();

        foreach (m10[i]) m10[i] = 16'hFF00;
        m10[3] = 16'h0100; m10[7] = 16'h0100;
        push(10, 16'd3, 16'h0100, cyc + 13);
        pulse10();
        drain();

        for (int i = 0; i < 9; i++) m10[i] = 16'hFE00 + 16'(i);
        m10[9] = 16'hFFFF;
        push(10, 16'd9, 16'hFFFF, cyc + 13);
        pulse10();
        drain();

        push(10, 16'd9, 16'hFFFF, cyc + 13);
        pulse10();
        tick(3);
        pulse10();
        drain();

        foreach (m10[i]) m10[i] = 16'hFF00;
        m10[5] = 16'h0A00;
        pulse10();
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midread_rst_rd_en", 32'(en10), 32'(0));
        chk("midread_rst_busy", 32'(busy10), 32'(0));
        chk("midread_rst_rd_addr", 32'(addr10), 32'(0));
        chk("midread_rst_class", 32'(cls10), 32'(0));
        chk("midread_rst_max", 32'(mx10), 32'(0));
        tick(20);
        push(10, 16'd5, 16'h0A00, cyc + 13);
        pulse10();
        drain();

        m1[0] = 16'h8000;
        push(1, 16'd0, 16'h8000, cyc + 4);
        push(1, 16'd0, 16'h8000, cyc + 8);
        push(1, 16'd0, 16'h8000, cyc + 12);
        s1 = 1'b1; tick(9); s1 = 1'b0;
        drain();
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
